// File: rtl/memchk_pkg.sv
// Shared types and defaults for the memory-write verdict checker.
// The optional cycle timeout is enabled by defining MEMCHK_TIMEOUT_EN.
package memchk_pkg;

    // Checker FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_e;

    // Default signature and scratch addresses.
    localparam logic [31:0] DEF_PASS_ADR    = 32'd100;
    localparam logic [31:0] DEF_PASS_DATA   = 32'd7;
    localparam logic [31:0] DEF_SCRATCH_ADR = 32'd96;

    // One observed store as it is kept in the history buffer.
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } store_t;

    // Pack a store into a history word: address in the upper half.
    function automatic logic [63:0] pack_store(input logic [31:0] adr, input logic [31:0] data);
        store_t s;
        s.adr  = adr;
        s.data = data;
        return s;
    endfunction

endpackage

// File: rtl/memwrite_checker_if.sv
// Data-memory write bus as driven by the processor and observed by the checker.
interface memwrite_checker_if;
    logic        MemWrite;
    logic [31:0] Adr;
    logic [31:0] WriteData;

    modport master (output MemWrite, output Adr, output WriteData);
    modport slave  (input  MemWrite, input  Adr, input  WriteData);
endinterface

// File: rtl/memchk_hist_buf.sv
// Circular history of recent stores. Index 0 on the read side is the most
// recent write; entries never written since reset read as zero.
module memchk_hist_buf #(
    parameter  int DEPTH = 4,
    parameter  int W     = 64,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [W-1:0]  wdata,
    input  logic [IW-1:0] rd_idx,
    output logic [W-1:0]  rdata
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [IW-1:0] wr_ptr_q;
    logic [IW-1:0] rd_ptr_s;

    // Write the new entry at wr_ptr and advance it; DEPTH is a power of two so the pointer wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
            wr_ptr_q <= {IW{1'b0}};
        end else if (we) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + IW'(1);
        end
    end

    // Map the age-relative read index onto a physical slot and read it out.
    always_comb begin
        rd_ptr_s = wr_ptr_q - IW'(1) - rd_idx;
        rdata    = mem_q[rd_ptr_s];
    end

endmodule

// File: rtl/memwrite_checker.sv
// Verdict monitor on the processor's data-memory write bus.
// PASS on the signature store, FAIL on any store outside the scratch word;
// verdicts are sticky until reset. Define MEMCHK_TIMEOUT_EN to also FAIL
// after TIMEOUT cycles in RUN without a verdict.
module memwrite_checker
    import memchk_pkg::*;
#(
    parameter  logic [31:0] PASS_ADR    = DEF_PASS_ADR,
    parameter  logic [31:0] PASS_DATA   = DEF_PASS_DATA,
    parameter  logic [31:0] SCRATCH_ADR = DEF_SCRATCH_ADR,
    parameter  int          CNT_W       = 16,
    parameter  int          HIST_DEPTH  = 4,
    parameter  int          TIMEOUT     = 1000,
    localparam int          IDX_W       = $clog2(HIST_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    memwrite_checker_if.slave  bus,
    input  logic [IDX_W-1:0]   hist_idx,
    output logic [31:0]        hist_adr,
    output logic [31:0]        hist_data,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic               timeout,
    output logic [31:0]        fail_adr,
    output logic [31:0]        fail_data,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   store_count
);

    state_e             state_q, state_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               timeout_q, timeout_d;
    logic [31:0]        fail_adr_q, fail_adr_d;
    logic [31:0]        fail_data_q, fail_data_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   store_q, store_d;
    logic               hist_we_s;
    logic [63:0]        hist_rdata_s;
    logic               unused_timeout_s;

    // Saturating increment shared by both counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Keeps TIMEOUT referenced in builds where the timeout is compiled out.
    assign unused_timeout_s = (TIMEOUT > 0);

    // Next-state, verdict capture and counter update for the checker FSM.
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        fail_adr_d  = fail_adr_q;
        fail_data_d = fail_data_q;
        cycle_d     = cycle_q;
        store_d     = store_q;
        hist_we_s   = 1'b0;

        case (state_q)
            IDLE: begin
                // Stores seen while idle are deliberately ignored.
                state_d = RUN;
            end
            RUN: begin
                if (bus.MemWrite) begin
                    hist_we_s = 1'b1;
                    store_d   = sat_inc(store_q);
                    if ((bus.Adr == PASS_ADR) && (bus.WriteData == PASS_DATA)) begin
                        state_d = PASS;
                        pass_d  = 1'b1;
                    end else if (bus.Adr != SCRATCH_ADR) begin
                        state_d     = FAIL;
                        fail_d      = 1'b1;
                        fail_adr_d  = bus.Adr;
                        fail_data_d = bus.WriteData;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
`ifdef MEMCHK_TIMEOUT_EN
                // A store verdict on this edge takes priority over the timeout.
                if ((state_d == RUN) && (cycle_q == CNT_W'(TIMEOUT - 1))) begin
                    state_d   = FAIL;
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    timeout_d = timeout_q;
                end
`else
                timeout_d = 1'b0;
`endif
                // The cycle counter only advances on edges that stay in RUN,
                // so it freezes at its value on the verdict edge.
                if (state_d == RUN) begin
                    cycle_d = sat_inc(cycle_q);
                end else begin
                    cycle_d = cycle_q;
                end
            end
            PASS: begin
                state_d = PASS;
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = pass_d | fail_d;
    end

    // State, verdict and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_adr_q  <= 32'd0;
            fail_data_q <= 32'd0;
            cycle_q     <= {CNT_W{1'b0}};
            store_q     <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            fail_adr_q  <= fail_adr_d;
            fail_data_q <= fail_data_d;
            cycle_q     <= cycle_d;
            store_q     <= store_d;
        end
    end

    memchk_hist_buf #(
        .DEPTH (HIST_DEPTH),
        .W     (64)
    ) u_hist (
        .clk    (clk),
        .reset  (reset),
        .we     (hist_we_s),
        .wdata  (pack_store(bus.Adr, bus.WriteData)),
        .rd_idx (hist_idx),
        .rdata  (hist_rdata_s)
    );

    assign hist_adr    = hist_rdata_s[63:32];
    assign hist_data   = hist_rdata_s[31:0];
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign fail_adr    = fail_adr_q;
    assign fail_data   = fail_data_q;
    assign cycle_count = cycle_q;
    assign store_count = store_q;

endmodule

// File: tb/tb_memwrite_checker.sv
// Bench for memwrite_checker: a rule-level model checked every cycle plus
// hand-computed expectations for the directed scenarios.
module tb_memwrite_checker;

    localparam int CNT_W = 5;
    localparam int HD    = 4;
    localparam int TO    = 20;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef MEMCHK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       hist_idx = 2'd0;
    logic [31:0]      hist_adr, hist_data, fail_adr, fail_data;
    logic             done, pass, fail, timeout;
    logic [CNT_W-1:0] cycle_count, store_count;

    memwrite_checker_if bus();

    memwrite_checker #(
        .CNT_W      (CNT_W),
        .HIST_DEPTH (HD),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .hist_idx    (hist_idx),
        .hist_adr    (hist_adr),
        .hist_data   (hist_data),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .fail_adr    (fail_adr),
        .fail_data   (fail_data),
        .cycle_count (cycle_count),
        .store_count (store_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase = 0;   // 0 idle, 1 running, 2 verdict reached
    bit          m_pass = 1'b0, m_fail = 1'b0, m_to = 1'b0;
    logic [31:0] m_fadr = 32'd0, m_fdata = 32'd0;
    int          m_cyc = 0, m_st = 0;
    logic [63:0] hq[$];

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_pass = 1'b0; m_fail = 1'b0; m_to = 1'b0;
            m_fadr = 32'd0; m_fdata = 32'd0; m_cyc = 0; m_st = 0;
            hq.delete();
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (bus.MemWrite) begin
                hq.push_back({bus.Adr, bus.WriteData});
                if (hq.size() > HD) hq.delete(0);
                if (m_st < MAXC) m_st++;
                if (bus.Adr == 32'd100 && bus.WriteData == 32'd7) begin
                    m_pass = 1'b1; m_phase = 2;
                end else if (bus.Adr != 32'd96) begin
                    m_fail = 1'b1; m_fadr = bus.Adr; m_fdata = bus.WriteData; m_phase = 2;
                end
            end
            if (m_phase == 1 && TO_EN && m_cyc == TO - 1) begin
                m_fail = 1'b1; m_to = 1'b1; m_phase = 2;
            end
            if (m_phase == 1 && m_cyc < MAXC) m_cyc++;
        end
    end

    bit chk_en = 1'b0;

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            int idx;
            logic [63:0] e;
            idx = int'(hist_idx);
            e = (idx < hq.size()) ? hq[hq.size() - 1 - idx] : 64'd0;
            chk("m_pass",      pass,        32'(m_pass));
            chk("m_fail",      fail,        32'(m_fail));
            chk("m_done",      done,        32'(m_pass | m_fail));
            chk("m_timeout",   timeout,     32'(m_to));
            chk("m_fail_adr",  fail_adr,    m_fadr);
            chk("m_fail_data", fail_data,   m_fdata);
            chk("m_cycles",    cycle_count, 32'(m_cyc));
            chk("m_stores",    store_count, 32'(m_st));
            chk("m_hist_adr",  hist_adr,    e[63:32]);
            chk("m_hist_data", hist_data,   e[31:0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite  = 1'b1;
        bus.Adr       = a;
        bus.WriteData = d;
        tick(1);
        bus.MemWrite  = 1'b0;
    endtask

    task automatic restart();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        bus.MemWrite = 1'b0; bus.Adr = 32'd0; bus.WriteData = 32'd0;
        reset = 1'b1;
        tick(2);
        chk_en = 1'b1;
        #1;
        chk("rst_pass", pass, 32'd0);
        chk("rst_stores", store_count, 32'd0);
        chk("rst_cycles", cycle_count, 32'd0);

        // 1: scratch stores then the signature store
        reset = 1'b0;
        tick(2);
        store(32'd96, 32'd3);
        store(32'd96, 32'd5);
        store(32'd100, 32'd7);
        #1;
        chk("t1_pass", pass, 32'd1);
        chk("t1_fail", fail, 32'd0);
        chk("t1_stores", store_count, 32'd3);
        chk("t1_cycles", cycle_count, 32'd3);
        hist_idx = 2'd0; #1;
        chk("t1_h0_adr", hist_adr, 32'd100);
        chk("t1_h0_data", hist_data, 32'd7);
        hist_idx = 2'd1; #1;
        chk("t1_h1_adr", hist_adr, 32'd96);
        chk("t1_h1_data", hist_data, 32'd5);
        hist_idx = 2'd0;
        store(32'd104, 32'd1);
        #1;
        chk("t1_sticky_pass", pass, 32'd1);
        chk("t1_sticky_fail", fail, 32'd0);
        chk("t1_sticky_stores", store_count, 32'd3);

        // 5: reset right after PASS, then the signature store again
        reset = 1'b1;
        tick(1);
        #1;
        chk("t5_rst_pass", pass, 32'd0);
        chk("t5_rst_done", done, 32'd0);
        chk("t5_rst_stores", store_count, 32'd0);
        chk("t5_rst_hist", hist_adr, 32'd0);
        reset = 1'b0;
        tick(1);
        store(32'd100, 32'd7);
        #1;
        chk("t5_pass", pass, 32'd1);
        chk("t5_stores", store_count, 32'd1);
        chk("t5_cycles", cycle_count, 32'd0);

        // 2: illegal address
        restart();
        store(32'd104, 32'd7);
        #1;
        chk("t2_fail", fail, 32'd1);
        chk("t2_pass", pass, 32'd0);
        chk("t2_done", done, 32'd1);
        chk("t2_fail_adr", fail_adr, 32'd104);
        chk("t2_fail_data", fail_data, 32'd7);

        // 3: signature address with wrong data
        restart();
        store(32'd100, 32'd8);
        #1;
        chk("t3_fail", fail, 32'd1);
        chk("t3_fail_adr", fail_adr, 32'd100);
        chk("t3_fail_data", fail_data, 32'd8);

        // 4: store during IDLE is ignored, then six scratch stores wrap history
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        bus.MemWrite = 1'b1; bus.Adr = 32'd104; bus.WriteData = 32'd9;
        tick(1);
        bus.MemWrite = 1'b0;
        #1;
        chk("t4_idle_fail", fail, 32'd0);
        chk("t4_idle_stores", store_count, 32'd0);
        for (int i = 1; i <= 6; i++) begin
            hist_idx = 2'(i);
            store(32'd96, 32'(i));
        end
        #1;
        chk("t4_stores", store_count, 32'd6);
        chk("t4_done", done, 32'd0);
        hist_idx = 2'd3; #1;
        chk("t4_h3_adr", hist_adr, 32'd96);
        chk("t4_h3_data", hist_data, 32'd3);
        hist_idx = 2'd0; #1;
        chk("t4_h0_data", hist_data, 32'd6);

`ifdef MEMCHK_TIMEOUT_EN
        // 6: no stores until the timeout fires
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(25);
        #1;
        chk("t6_fail", fail, 32'd1);
        chk("t6_timeout", timeout, 32'd1);
        chk("t6_cycles", cycle_count, 32'd19);
        chk("t6_fail_adr", fail_adr, 32'd0);
        chk("t6_pass", pass, 32'd0);
`else
        // Counter saturation and no timeout without the option
        restart();
        tick(40);
        #1;
        chk("sat_cycles", cycle_count, 32'(MAXC));
        chk("sat_timeout", timeout, 32'd0);
        chk("sat_done", done, 32'd0);
        for (int i = 0; i < 35; i++) begin
            store(32'd96, 32'(i));
        end
        #1;
        chk("sat_stores", store_count, 32'(MAXC));
        chk("sat_done2", done, 32'd0);
`endif

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
